uart_autobaud: RTL and testbench
================================

// Module: uart_autobaud
// PURPOSE
//  Divider-parameter controller for the basic_uart baud-rate generator. Drives the generator's
//  16-bit prer input, from a software write or an auto-baud measurement on the RX line.
//  For a measurement, the host sends the sync character 0x55 ('U', 8N1). The block times 8 bit
//  periods and loads the rounded clocks-per-bit value. Sits between the register interface and
//  uart_brgene; also holds the UART receiver off while measuring.
// PARAMETERS
//  PRER_RESET   16'd434  o_prer value after reset
//  MIN_PRER     16'd16   smallest accepted measured prer; smaller results flag an error
//  SYNC_STAGES  2        i_rxd synchroniser depth (>=2)
// PORTS
//  i_clk         in   1   system clock
//  i_reset       in   1   reset, asynchronous, active-high
//  i_rxd         in   1   raw serial RX line (async, idle high)
//  i_start       in   1   1-cycle pulse: arm an auto-baud measurement
//  i_abort       in   1   1-cycle pulse: cancel measurement in progress
//  i_prer_we     in   1   software write strobe for prer
//  i_prer_wdata  in   16  software prer value
//  o_prer        out  16  divider parameter to baud-rate generator (registered)
//  o_busy        out  1   high in WAIT_START and MEASURE
//  o_done        out  1   1-cycle pulse: measurement accepted, o_prer updated
//  o_err         out  1   1-cycle pulse: measurement rejected, o_prer unchanged
//  o_rxhold      out  1   equals o_busy; receiver ignores line while high
// BEHAVIOUR
//  Reset: state IDLE; o_prer=PRER_RESET; o_busy=o_done=o_err=o_rxhold=0.
//   Synchroniser flops reset to 1 (idle line); count=0; edge count=0.
//  RX line: i_rxd passes through SYNC_STAGES flops, then one more register.
//   Falling edge = prev 1 and cur 0, detected on the synced signal.
//  FSM states:
//   IDLE: i_start -> WAIT_START.
//   WAIT_START: first falling edge -> MEASURE; count=0 and edges=1 on entry.
//   MEASURE: count increments every cycle (19-bit). Each falling edge increments edges.
//    The 5th falling edge (S,d1,d3,d5,d7 of 0x55) ends the measurement and moves to IDLE.
//    At that point count = cycles between the edge-1 and edge-5 detections (8 bit times).
//  Result: prer_m = (count + 4) >> 3, i.e. round-to-nearest, truncated to 16 bits.
//   Accept if count did not saturate and prer_m >= MIN_PRER.
//   On accept: o_prer <= prer_m and o_done=1, one cycle after the edge-5 detection cycle.
//   On reject: o_err=1 in that same cycle; o_prer is held.
//  Saturation: count reaches 19'h7FFFF before edge 5 -> o_err pulse and IDLE next cycle.
//   This is also the no-traffic timeout.
//  WAIT_START has no timeout; exit only by edge or i_abort.
//  i_abort in WAIT_START/MEASURE: IDLE next cycle; no o_done/o_err; o_prer unchanged.
//   i_abort in IDLE: ignored.
//  i_start while busy: ignored. i_start and i_abort in the same cycle: abort wins.
//  i_prer_we: o_prer <= i_prer_wdata next cycle, in any state.
//   If it coincides with a measurement result, the software value wins.
//   o_done/o_err still pulse; the FSM is not disturbed.
//  o_busy/o_rxhold: registered; high from the cycle after i_start until the return to IDLE.
//  o_prer changes only on a software write or an accepted measurement. No glitches; one
//   clock domain.
// TESTING
//  1. Reset -> o_prer=434, o_busy=0; then i_prer_we with 16'h1234 -> o_prer=16'h1234 one cycle later.
//  2. i_start, then 0x55 at 100 clk/bit -> count=800, o_prer=100, o_done pulses once,
//     o_busy falls in the same cycle.
//  3. Edge spacings summing to count=804 -> o_prer=101; count=803 -> o_prer=100 (rounding).
//  4. 0x55 at 1 clk/bit (count=8, prer_m=1 < 16) -> o_err pulse, o_prer unchanged.
//     Line stuck after 2 edges -> o_err at saturation (2^19-1 cycles).
//  5. i_abort mid-MEASURE after 3 edges -> IDLE next cycle, no done/err.
//     A new i_start, then 0x55 at 50 clk/bit -> o_prer=50.
//  6. i_prer_we(16'd777) in the edge-5 completion cycle -> o_prer=777 and o_done pulses.
//     Async i_reset mid-MEASURE -> all outputs to reset values immediately.

Source files
------------

// File: rtl/uart_autobaud.sv
// Auto-baud divider controller: holds the baud generator's prer value, loaded by software
// or by timing eight bit periods of a 0x55 sync character on the RX line.
module uart_autobaud #(
  parameter logic [15:0] PRER_RESET  = 16'd434,
  parameter logic [15:0] MIN_PRER    = 16'd16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rxd,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_prer_we,
  input  logic [15:0] i_prer_wdata,
  output logic [15:0] o_prer,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_rxhold
);

  typedef enum logic [1:0] {IDLE, WAIT_START, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] rxd_sync;
  logic                   rxd_prev;
  logic [18:0]            count;
  logic [2:0]             edges;

  logic        fall;
  logic [19:0] cnt_inc;
  logic [19:0] cnt_round;
  logic [15:0] prer_m;
  logic        sat;

  // Line idles high, so the synchroniser resets to 1 to avoid a false edge after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rxd_sync <= '1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], i_rxd};
      rxd_prev <= rxd_sync[SYNC_STAGES-1];
    end
  end

  assign fall      = rxd_prev & ~rxd_sync[SYNC_STAGES-1];
  // The result uses the count including the current cycle, i.e. the exact edge-1 to edge-5 distance.
  assign cnt_inc   = {1'b0, count} + 20'd1;
  assign cnt_round = cnt_inc + 20'd4;
  assign prer_m    = cnt_round[18:3];
  assign sat       = (cnt_inc >= 20'h7FFFF);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      o_prer <= PRER_RESET;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
      count  <= '0;
      edges  <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_abort) begin
            state  <= WAIT_START;
            o_busy <= 1'b1;
          end
        end
        WAIT_START: begin
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (fall) begin
            state <= MEASURE;
            count <= '0;
            edges <= 3'd1;
          end
        end
        MEASURE: begin
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            count <= cnt_inc[18:0];
            if (fall)
              edges <= edges + 3'd1;
            if (fall && edges == 3'd4) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              if (!sat && prer_m >= MIN_PRER) begin
                o_prer <= prer_m;
                o_done <= 1'b1;
              end else begin
                o_err <= 1'b1;
              end
            end else if (sat) begin
              // Saturation doubles as the no-traffic timeout.
              state  <= IDLE;
              o_busy <= 1'b0;
              o_err  <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
      // Software write overrides any measurement result landing in the same cycle.
      if (i_prer_we)
        o_prer <= i_prer_wdata;
    end
  end

  assign o_rxhold = o_busy;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: directed cases plus randomized sync characters
// compared against an arithmetic model of the measurement rules.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        start;
  logic        abort;
  logic        prer_we;
  logic [15:0] prer_wdata;
  logic [15:0] prer;
  logic        busy;
  logic        done;
  logic        err;
  logic        rxhold;

  int total = 0;
  int bad   = 0;
  logic [15:0] model_prer;

  always #5 clk = ~clk;

  uart_autobaud dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rxd        (rxd),
    .i_start      (start),
    .i_abort      (abort),
    .i_prer_we    (prer_we),
    .i_prer_wdata (prer_wdata),
    .o_prer       (prer),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_rxhold     (rxhold)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives n falling edges; sp[i] is the clock distance from edge i to edge i+1.
  // The line is left low after the last edge, with no clock consumed after it.
  task automatic drive_edges(input int sp[4], input int n);
    int lo;
    for (int i = 0; i < n; i++) begin
      rxd = 1'b0;
      if (i < n - 1) begin
        lo = (sp[i] / 2 < 1) ? 1 : sp[i] / 2;
        repeat (lo) tick();
        rxd = 1'b1;
        repeat (sp[i] - lo) tick();
      end
    end
  endtask

  // Full measurement: arm, send 5 edges, compare outcome against the rule-based model.
  task automatic measure(input string tag, input int sp[4], input bit we_hit, input logic [15:0] we_val);
    int   sum;
    int   rounded;
    bit   exp_ok;
    int   lat;
    logic got_done, got_err, got_busy;
    sum = sp[0] + sp[1] + sp[2] + sp[3];
    rounded = ((sum + 4) >> 3) & 16'hFFFF;
    exp_ok  = (sum < 'h7FFFF) && (rounded >= 16);
    pulse_start();
    check({tag, " busy_armed"}, {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    repeat ($urandom_range(5, 2)) tick();
    drive_edges(sp, 5);
    lat = 0;
    got_done = 1'b0;
    got_err  = 1'b0;
    got_busy = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (lat == 0) begin
        if (we_hit && c == 3) begin
          prer_we    = 1'b1;
          prer_wdata = we_val;
        end
        tick();
        prer_we = 1'b0;
        if (done || err) begin
          lat      = c;
          got_done = done;
          got_err  = err;
          got_busy = busy;
        end
      end
    end
    if (we_hit)      model_prer = we_val;
    else if (exp_ok) model_prer = rounded[15:0];
    check({tag, " latency"}, lat, 3);
    check({tag, " done"}, {31'd0, got_done}, {31'd0, exp_ok});
    check({tag, " err"}, {31'd0, got_err}, {31'd0, !exp_ok});
    check({tag, " busy_fall"}, {31'd0, got_busy}, 32'd0);
    check({tag, " prer"}, {16'd0, prer}, {16'd0, model_prer});
    rxd = 1'b1;
    tick();
    check({tag, " single_pulse"}, {30'd0, done, err}, 32'd0);
    repeat (3) tick();
    $display("measure %s sum=%0d prer=%0d done=%0d err=%0d", tag, sum, prer, got_done, got_err);
  endtask

  initial begin
    int sp[4];
    int k;
    int extra;
    bit seen;
    rst = 1'b1; rxd = 1'b1; start = 1'b0; abort = 1'b0;
    prer_we = 1'b0; prer_wdata = 16'd0;
    model_prer = 16'd434;
    repeat (2) tick();
    check("reset prer", {16'd0, prer}, 32'd434);
    check("reset flags", {28'd0, busy, done, err, rxhold}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    prer_we = 1'b1; prer_wdata = 16'h1234;
    tick();
    prer_we = 1'b0;
    model_prer = 16'h1234;
    check("sw write", {16'd0, prer}, 32'h1234);
    $display("sw write prer=%h", prer);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start+abort", {31'd0, busy}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort idle", {16'd0, prer}, {16'd0, model_prer});

    measure("100cpb", '{200, 200, 200, 200}, 1'b0, 16'd0);
    check("rxhold idle", {31'd0, rxhold}, 32'd0);
    measure("r804", '{201, 201, 201, 201}, 1'b0, 16'd0);
    measure("r803", '{201, 201, 201, 200}, 1'b0, 16'd0);
    measure("min_ok", '{31, 31, 31, 31}, 1'b0, 16'd0);
    measure("min_bad", '{31, 31, 31, 30}, 1'b0, 16'd0);
    measure("1cpb", '{2, 2, 2, 2}, 1'b0, 16'd0);

    // Abort after three edges, then measure again.
    pulse_start();
    check("abort armed rxhold", {31'd0, rxhold}, 32'd1);
    drive_edges('{100, 100, 100, 100}, 3);
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    rxd = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (done || err) seen = 1'b1;
      tick();
    end
    check("abort quiet", {31'd0, seen}, 32'd0);
    check("abort prer", {16'd0, prer}, {16'd0, model_prer});
    $display("abort mid-measure busy=%0d", busy);
    measure("50cpb", '{100, 100, 100, 100}, 1'b0, 16'd0);

    measure("we_hit", '{120, 130, 110, 140}, 1'b1, 16'd777);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        prer_we = 1'b1;
        prer_wdata = 16'($urandom);
        tick();
        prer_we = 1'b0;
        model_prer = prer_wdata;
        check("rand sw write", {16'd0, prer}, {16'd0, model_prer});
      end
      for (int i = 0; i < 4; i++)
        sp[i] = ($urandom_range(4, 0) == 0) ? int'($urandom_range(40, 2)) : int'($urandom_range(400, 2));
      measure("rand", sp, 1'b0, 16'd0);
    end

    // Async reset mid-measure.
    prer_we = 1'b1; prer_wdata = 16'd555;
    tick();
    prer_we = 1'b0;
    pulse_start();
    drive_edges('{60, 60, 60, 60}, 3);
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("async rst prer", {16'd0, prer}, 32'd434);
    check("async rst flags", {28'd0, busy, done, err, rxhold}, 32'd0);
    $display("async reset prer=%0d busy=%0d", prer, busy);
    rxd = 1'b1;
    tick();
    rst = 1'b0;
    model_prer = 16'd434;
    repeat (4) tick();

    // Stuck line after two edges: timeout at counter saturation.
    pulse_start();
    rxd = 1'b0;
    k = 0;
    extra = 0;
    seen = 1'b0;
    while (!seen && k < (1 << 19) + 50) begin
      tick();
      k++;
      if (k == 5)  rxd = 1'b1;
      if (k == 10) rxd = 1'b0;
      if (err) begin
        seen = 1'b1;
        extra = {29'd0, busy, done, 1'b0};
      end
    end
    check("sat latency", k, (1 << 19) + 2);
    check("sat err", {31'd0, seen}, 32'd1);
    check("sat busy/done", extra, 0);
    check("sat prer", {16'd0, prer}, {16'd0, model_prer});
    $display("saturation err after %0d cycles", k);

    rxd = 1'b1;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
